// File: rtl/ifu_fetch_pkg.sv
// Shared constants for the instruction-fetch slice: reset vector, RV opcodes, FSM encoding.
package ifu_fetch_pkg;

  localparam logic [63:0] RESET_PC  = 64'h8000_0000;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus: redirect/stall from the pipeline, imem request/response, IF/ID output slot.
interface ifu_fetch_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              id_stall;
  logic              imem_req_valid;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_jump;

  modport master (
    input  redirect_valid, redirect_pc, id_stall,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_inst, if_jump
  );

  modport slave (
    output redirect_valid, redirect_pc, id_stall,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_inst, if_jump
  );
endinterface

// File: rtl/ifu_predecode.sv
// Static branch predictor: JAL and backward conditional branches predicted taken.
module ifu_predecode
  import ifu_fetch_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            pred_o,
  output logic [PC_W-1:0] target_o
);

  logic [PC_W-1:0] imm_j;
  logic [PC_W-1:0] imm_b;

  assign imm_j = {{(PC_W-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_b = {{(PC_W-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  always_comb begin
    pred_o   = 1'b0;
    target_o = pc_i + PC_W'(4);
    if (inst_i[6:0] == OP_JAL) begin
      pred_o   = 1'b1;
      target_o = pc_i + imm_j;
    end else if (inst_i[6:0] == OP_BRANCH && inst_i[31]) begin
      pred_o   = 1'b1;
      target_o = pc_i + imm_b;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetcher feeding the IF/ID register, with predecode and redirect/drain.
module ifu_fetch #(
  parameter int          PC_W     = 64,
  parameter int          INST_W   = 32,
  parameter logic [63:0] RESET_PC = ifu_fetch_pkg::RESET_PC
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  import ifu_fetch_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              vld_q, vld_d;
  logic [PC_W-1:0]   ipc_q, ipc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              jump_q, jump_d;
  logic              pred;
  logic [PC_W-1:0]   target;
  logic              busy;

  ifu_predecode #(.PC_W(PC_W)) u_pdec (
    .inst_i   (bus.imem_resp_data),
    .pc_i     (pc_q),
    .pred_o   (pred),
    .target_o (target)
  );

  assign bus.imem_req_valid = (state_q == ST_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = vld_q;
  assign bus.if_pc          = ipc_q;
  assign bus.if_inst        = inst_q;
  assign bus.if_jump        = jump_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    ipc_d   = ipc_q;
    inst_d  = inst_q;
    jump_d  = jump_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   if (bus.imem_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.imem_resp_valid) begin
          vld_d   = 1'b1;
          ipc_d   = pc_q;
          inst_d  = bus.imem_resp_data;
          jump_d  = pred;
          pc_d    = target;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bus.id_stall) begin
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: if (bus.imem_resp_valid) state_d = ST_REQ;
      default:  state_d = ST_IDLE;
    endcase
    // A request accepted but not yet answered must have its response swallowed in DRAIN.
    if (bus.redirect_valid) begin
      busy    = ((state_q == ST_WAIT || state_q == ST_DRAIN) && !bus.imem_resp_valid) ||
                (state_q == ST_REQ && bus.imem_req_ready);
      pc_d    = bus.redirect_pc;
      vld_d   = 1'b0;
      ipc_d   = '0;
      inst_d  = '0;
      jump_d  = 1'b0;
      state_d = busy ? ST_DRAIN : ST_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC[PC_W-1:0];
      vld_q   <= 1'b0;
      ipc_q   <= '0;
      inst_q  <= '0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      inst_q  <= inst_d;
      jump_q  <= jump_d;
    end
  end

endmodule
